// File: rtl/prescaled_counter.sv
`default_nettype none
// ============================================================================
// Module      : prescaled_counter
// Description : Free-running up/down counter advanced once every PRESCALE
//               enabled clocks. It supports synchronous load and wrap or
//               saturate behaviour at the limits. It emits registered
//               one-cycle tick (step) and tc (limit event) strobes.
//               Optional feature macro: COUNTER_MATCH_EN adds the match_val
//               input and a registered match strobe.
// Revision    : 1.0  initial release
// ============================================================================
module prescaled_counter #(
  parameter int WIDTH    = 4,
  parameter int PRESCALE = 2,
  parameter int MODE     = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dir,
  output logic [WIDTH-1:0] y,
  output logic             tick,
  output logic             tc
`ifdef COUNTER_MATCH_EN
  ,
  input  logic [WIDTH-1:0] match_val,
  output logic             match
`endif
);

  // Prescaler needs at least one bit even when every clock is a step.
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  localparam logic [PW-1:0]    c_PRE_LAST = PW'(PRESCALE - 1);
  localparam logic [PW-1:0]    c_PRE_ONE  = PW'(1);
  localparam logic [WIDTH-1:0] c_ONE      = WIDTH'(1);
  localparam logic [WIDTH-1:0] c_MAX      = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] c_ZERO     = {WIDTH{1'b0}};

  logic [WIDTH-1:0] y_q, y_d;
  logic [PW-1:0]    pre_q, pre_d;
  logic             tick_q, tick_d;
  logic             tc_q, tc_d;
  logic             step_w;
  logic             at_limit_w;

`ifdef COUNTER_MATCH_EN
  logic             match_q, match_d;
`endif

  // Step fires on the last enabled clock of each prescale period; load wins.
  assign step_w     = en && !load && (pre_q == c_PRE_LAST);
  // Limit depends on the direction sampled at the step edge.
  assign at_limit_w = dir ? (y_q == c_MAX) : (y_q == c_ZERO);

  // Next-state logic: load > step > prescale advance > hold; strobes default low.
  always_comb begin
    y_d    = y_q;
    pre_d  = pre_q;
    tick_d = 1'b0;
    tc_d   = 1'b0;
    if (load) begin
      y_d   = load_val;
      pre_d = '0;
    end else if (en) begin
      if (step_w) begin
        pre_d  = '0;
        tick_d = 1'b1;
        if (at_limit_w) begin
          tc_d = 1'b1;
          // Saturate mode holds y; wrap mode jumps to the opposite limit.
          if (MODE == 0) begin
            y_d = dir ? c_ZERO : c_MAX;
          end
        end else begin
          y_d = dir ? (y_q + c_ONE) : (y_q - c_ONE);
        end
      end else begin
        pre_d = pre_q + c_PRE_ONE;
      end
    end
  end

`ifdef COUNTER_MATCH_EN
  // Match is only evaluated when y is (re)written by a step or a load.
  always_comb begin
    match_d = 1'b0;
    if (load || step_w) begin
      match_d = (y_d == match_val);
    end
  end
`endif

  // State and strobe registers with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_q    <= '0;
      pre_q  <= '0;
      tick_q <= 1'b0;
      tc_q   <= 1'b0;
    end else begin
      y_q    <= y_d;
      pre_q  <= pre_d;
      tick_q <= tick_d;
      tc_q   <= tc_d;
    end
  end

`ifdef COUNTER_MATCH_EN
  // Match strobe register with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      match_q <= 1'b0;
    end else begin
      match_q <= match_d;
    end
  end

  assign match = match_q;
`endif

  assign y    = y_q;
  assign tick = tick_q;
  assign tc   = tc_q;

endmodule
`default_nettype wire

// File: tb/tb_prescaled_counter.sv
`default_nettype none
// ============================================================================
// Module      : tb_prescaled_counter
// Description : Self-checking bench for prescaled_counter. It runs four
//               parameterisations side by side. Each output is compared
//               every cycle against an arithmetic reference model. Directed
//               scenarios are followed by randomized stimulus.
// Revision    : 1.0  initial release
// ============================================================================
module tb_prescaled_counter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       en;
  logic       load;
  logic       dir;
  logic [3:0] load_val;
  logic [3:0] match_val;

  logic [3:0] y0, y1;
  logic [2:0] y2;
  logic [0:0] y3;
  logic [3:0] tk, tcv, mt;

  prescaled_counter #(.WIDTH(4), .PRESCALE(2), .MODE(0)) u_dut0 (
    .clk(clk), .rst(rst), .en(en), .load(load), .load_val(load_val),
    .dir(dir), .y(y0), .tick(tk[0]), .tc(tcv[0])
`ifdef COUNTER_MATCH_EN
    , .match_val(match_val), .match(mt[0])
`endif
  );

  prescaled_counter #(.WIDTH(4), .PRESCALE(2), .MODE(1)) u_dut1 (
    .clk(clk), .rst(rst), .en(en), .load(load), .load_val(load_val),
    .dir(dir), .y(y1), .tick(tk[1]), .tc(tcv[1])
`ifdef COUNTER_MATCH_EN
    , .match_val(match_val), .match(mt[1])
`endif
  );

  prescaled_counter #(.WIDTH(3), .PRESCALE(3), .MODE(0)) u_dut2 (
    .clk(clk), .rst(rst), .en(en), .load(load), .load_val(load_val[2:0]),
    .dir(dir), .y(y2), .tick(tk[2]), .tc(tcv[2])
`ifdef COUNTER_MATCH_EN
    , .match_val(match_val[2:0]), .match(mt[2])
`endif
  );

  prescaled_counter #(.WIDTH(1), .PRESCALE(1), .MODE(1)) u_dut3 (
    .clk(clk), .rst(rst), .en(en), .load(load), .load_val(load_val[0:0]),
    .dir(dir), .y(y3), .tick(tk[3]), .tc(tcv[3])
`ifdef COUNTER_MATCH_EN
    , .match_val(match_val[0:0]), .match(mt[3])
`endif
  );

`ifndef COUNTER_MATCH_EN
  assign mt = 4'b0000;
`endif

  // Reference model configuration and state, one entry per instance.
  int cw[4] = '{4, 4, 3, 1};
  int cp[4] = '{2, 2, 3, 1};
  int cm[4] = '{0, 1, 0, 1};
  int ym[4], pm[4], etk[4], etc_q[4], emt[4];

  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] ydut(input int k);
    case (k)
      0:       return {28'b0, y0};
      1:       return {28'b0, y1};
      2:       return {29'b0, y2};
      default: return {31'b0, y3};
    endcase
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 4; k++) begin
      ym[k] = 0; pm[k] = 0; etk[k] = 0; etc_q[k] = 0; emt[k] = 0;
    end
  endtask

  // Behaviour at one clock edge, written from the counting rules with
  // plain modular arithmetic.
  task automatic model_edge();
    int mx, lim, stp;
    for (int k = 0; k < 4; k++) begin
      mx = (1 << cw[k]) - 1;
      etk[k] = 0; etc_q[k] = 0; emt[k] = 0; stp = 0;
      if (load) begin
        ym[k] = int'(load_val) & mx;
        pm[k] = 0;
        stp = 1;
      end else if (en) begin
        if (pm[k] == cp[k] - 1) begin
          pm[k] = 0;
          etk[k] = 1;
          stp = 1;
          lim = dir ? (ym[k] == mx) : (ym[k] == 0);
          etc_q[k] = lim;
          if (!(lim && cm[k] == 1))
            ym[k] = (ym[k] + (dir ? 1 : mx)) % (mx + 1);
        end else begin
          pm[k] = pm[k] + 1;
        end
      end
      if (stp && ym[k] == (int'(match_val) & mx)) emt[k] = 1;
    end
  endtask

  task automatic compare_all();
    for (int k = 0; k < 4; k++) begin
      check($sformatf("y[%0d]", k), ydut(k), ym[k]);
      check($sformatf("tick[%0d]", k), {31'b0, tk[k]}, etk[k]);
      check($sformatf("tc[%0d]", k), {31'b0, tcv[k]}, etc_q[k]);
`ifdef COUNTER_MATCH_EN
      check($sformatf("match[%0d]", k), {31'b0, mt[k]}, emt[k]);
`endif
    end
  endtask

  // One clock: update the model at the edge and check 1 time unit later.
  task automatic cyc();
    @(posedge clk);
    if (!rst) model_edge();
    #1;
    compare_all();
  endtask

  // Asynchronous reset pulse placed between edges.
  task automatic do_reset();
    #2 rst = 1'b1;
    #1 model_reset();
    #3 rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; load = 1'b0; dir = 1'b1;
    load_val = '0; match_val = 4'd5;
    model_reset();
    #12;
    compare_all();
    check("reset_y0", ydut(0), 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Up count from reset: first step at the 2nd edge, wrap at the 32nd.
    do_reset();
    en = 1'b1; dir = 1'b1;
    for (int e = 1; e <= 32; e++) begin
      cyc();
      if (e == 2)  begin check("up_first_y", ydut(0), 1); check("up_first_tick", {31'b0, tk[0]}, 1); end
      if (e == 30) check("up_y15", ydut(0), 15);
      if (e == 32) begin
        check("wrap_y", ydut(0), 0);
        check("wrap_tick", {31'b0, tk[0]}, 1);
        check("wrap_tc", {31'b0, tcv[0]}, 1);
      end
    end

    // Down count from reset wraps to all-ones immediately.
    do_reset();
    en = 1'b1; dir = 1'b0;
    for (int e = 1; e <= 4; e++) begin
      cyc();
      if (e == 2) begin check("down_y15", ydut(0), 15); check("down_tc", {31'b0, tcv[0]}, 1); end
      if (e == 4) check("down_y14", ydut(0), 14);
    end

    // Load mid-prescale restarts the prescaler.
    do_reset();
    en = 1'b1; dir = 1'b1;
    for (int e = 1; e <= 7; e++) cyc();
    check("pre_load_y", ydut(0), 3);
    load = 1'b1; load_val = 4'd9;
    cyc();
    check("load_y", ydut(0), 9);
    check("load_tick", {31'b0, tk[0]}, 0);
    load = 1'b0;
    cyc(); cyc();
    check("after_load_y", ydut(0), 10);
    check("after_load_tick", {31'b0, tk[0]}, 1);

    // Saturate mode at the upper limit keeps re-pulsing tc.
    do_reset();
    load = 1'b1; load_val = 4'd15;
    cyc();
    load = 1'b0; en = 1'b1; dir = 1'b1;
    for (int e = 1; e <= 6; e++) begin
      cyc();
      check("sat_y", ydut(1), 15);
      check("sat_tick", {31'b0, tk[1]}, (e % 2 == 0) ? 1 : 0);
      check("sat_tc", {31'b0, tcv[1]}, (e % 2 == 0) ? 1 : 0);
    end

    // Asynchronous reset takes effect before any clock edge.
    do_reset();
    en = 1'b1; dir = 1'b1;
    for (int e = 1; e <= 12; e++) cyc();
    check("mid_y6", ydut(0), 6);
    #2 rst = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) begin
      check("async_y", ydut(k), 0);
      check("async_tick", {31'b0, tk[k]}, 0);
      check("async_tc", {31'b0, tcv[k]}, 0);
    end
    model_reset();
    #3 rst = 1'b0;

    // Enable low holds both y and the prescaler phase.
    do_reset();
    en = 1'b1; dir = 1'b1;
    for (int e = 1; e <= 9; e++) cyc();
    en = 1'b0;
    for (int e = 1; e <= 5; e++) begin
      cyc();
      check("hold_y", ydut(0), 4);
    end
    en = 1'b1;
    cyc();
    check("resume_y", ydut(0), 5);
    check("resume_tick", {31'b0, tk[0]}, 1);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) do_reset();
      en        = ($urandom_range(0, 9) < 8);
      load      = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 15) == 0) dir = ~dir;
      load_val  = 4'($urandom);
      match_val = 4'($urandom);
      cyc();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    n_bad++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
